bbox_stream_multi: RTL and testbench

Streaming, multi-class successor to the frame-buffered bounding-box engine. It consumes the same 32-bit byte-write word ({byte, index}), packing RGB bytes in row-major order. Each pixel is classified against NUM_CLASSES programmable RGB ranges. A min/max box per class is accumulated on the fly, so the block needs no frame RAM. Results are read back one class at a time over the Avalon-style slave side.

---
 rtl/bbox_pkg.sv | 33 +++
 rtl/bbox_class_acc.sv | 58 +++++
 rtl/bbox_stream_multi.sv | 201 ++++++++++++++++++++
 tb/tb_bbox_stream_multi.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared types and helpers for the streaming multi-class bounding-box engine.
package bbox_pkg;

  localparam int unsigned CoordW        = 8;
  localparam int unsigned EndCmdDefault = 99999;

  typedef struct packed {
    logic [CoordW-1:0] x_min;
    logic [CoordW-1:0] y_min;
    logic [CoordW-1:0] x_max;
    logic [CoordW-1:0] y_max;
  } bbox_t;

  typedef struct packed {
    logic [23:0] lo;
    logic [23:0] hi;
  } rgb_range_t;

  typedef enum logic [1:0] {CompR, CompG, CompB} comp_e;

  // Unsigned per-component inclusive range test on a packed {R,G,B} pixel.
  function automatic logic rgb_in_range(logic [23:0] pix, rgb_range_t rng);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (pix[8*c +: 8] < rng.lo[8*c +: 8] || pix[8*c +: 8] > rng.hi[8*c +: 8]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bbox_class_acc.sv
// One colour class: registered range compare, then min/max box and found accumulation.
module bbox_class_acc
  import bbox_pkg::*;
#(
  parameter int unsigned CoordWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic [CoordWidth-1:0]   x_i,
  input  logic [CoordWidth-1:0]   y_i,
  input  logic [23:0]             pixel_i,
  input  rgb_range_t              range_i,
  output logic                    found_o,
  output logic [4*CoordWidth-1:0] box_o
);

  logic                  match_q;
  logic [CoordWidth-1:0] mx_q, my_q;
  logic                  found_q;
  logic [CoordWidth-1:0] x_min_q, y_min_q, x_max_q, y_max_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      match_q <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
      found_q <= 1'b0;
      x_min_q <= '0;
      y_min_q <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
    end else begin
      match_q <= valid_i && rgb_in_range(pixel_i, range_i);
      mx_q    <= x_i;
      my_q    <= y_i;
      if (match_q) begin
        if (!found_q) begin
          found_q <= 1'b1;
          x_min_q <= mx_q;
          y_min_q <= my_q;
          x_max_q <= mx_q;
          y_max_q <= my_q;
        end else begin
          if (mx_q < x_min_q) x_min_q <= mx_q;
          if (my_q < y_min_q) y_min_q <= my_q;
          if (mx_q > x_max_q) x_max_q <= mx_q;
          if (my_q > y_max_q) y_max_q <= my_q;
        end
      end
    end
  end

  assign found_o = found_q;
  assign box_o   = {x_min_q, y_min_q, x_max_q, y_max_q};

endmodule

// File: rtl/bbox_stream_multi.sv
// Streaming multi-class bounding-box engine: byte assembly, frame control, per-class
// accumulators and a registered per-class readout.
module bbox_stream_multi
  import bbox_pkg::*;
#(
  parameter int unsigned WIDTH       = 100,
  parameter int unsigned HEIGHT      = 100,
  parameter int unsigned NUM_CLASSES = 2,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned END_CMD     = EndCmdDefault,
  localparam int unsigned ClassW     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [31:0]            hex_value_index,
  input  logic                   cfg_wr,
  input  logic [ClassW-1:0]      cfg_class,
  input  logic [23:0]            cfg_lo,
  input  logic [23:0]            cfg_hi,
  input  logic                   rd_en,
  input  logic [ClassW-1:0]      rd_class,
  output logic [4*COORD_W-1:0]   coordinates,
  output logic                   rd_valid,
  output logic [NUM_CLASSES-1:0] found,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [23:0]        EndIdx     = 24'(END_CMD);
  localparam logic [23:0]        TotalBytes = 24'(WIDTH * HEIGHT * 3);
  localparam logic [COORD_W-1:0] XLast      = COORD_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StDone} state_e;

  state_e               state_q;
  logic                 drain_q;
  logic [23:0]          exp_idx_q;
  comp_e                comp_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [7:0]           r_q, g_q;
  logic                 pix_valid_q;
  logic [23:0]          pix_q;
  logic [COORD_W-1:0]   pix_x_q, pix_y_q;
  logic                 busy_q, done_q, err_q;
  logic                 rd_valid_q;
  logic [4*COORD_W-1:0] coord_q;
  rgb_range_t           range_q [NUM_CLASSES];

  logic [NUM_CLASSES-1:0] found_w;
  logic [4*COORD_W-1:0]   box_w [NUM_CLASSES];
  logic [4*COORD_W-1:0]   rd_box;

  logic [23:0] wr_idx;
  logic [7:0]  wr_byte;
  logic        start, cfg_err, cfg_ok;

  assign wr_idx  = hex_value_index[23:0];
  assign wr_byte = hex_value_index[31:24];
  assign start   = wr_en && (wr_idx == 24'd0);
  assign cfg_err = cfg_wr && busy_q;
  assign cfg_ok  = cfg_wr && !busy_q && (32'(cfg_class) < NUM_CLASSES);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      drain_q     <= 1'b0;
      exp_idx_q   <= '0;
      comp_q      <= CompR;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      g_q         <= '0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      if (start) begin
        // Index 0 restarts unconditionally and counts as the R byte of pixel (0,0).
        state_q   <= StBusy;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        err_q     <= cfg_err;
        r_q       <= wr_byte;
        comp_q    <= CompG;
        exp_idx_q <= 24'd1;
        x_q       <= '0;
        y_q       <= '0;
      end else begin
        if (wr_en) begin
          if (wr_idx == EndIdx) begin
            if (state_q == StBusy) begin
              state_q <= StDrain;
              busy_q  <= 1'b0;
              drain_q <= 1'b0;
              if (exp_idx_q != TotalBytes) err_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (state_q == StBusy && wr_idx == exp_idx_q && exp_idx_q != TotalBytes) begin
            exp_idx_q <= exp_idx_q + 24'd1;
            unique case (comp_q)
              CompR: begin
                r_q    <= wr_byte;
                comp_q <= CompG;
              end
              CompG: begin
                g_q    <= wr_byte;
                comp_q <= CompB;
              end
              default: begin
                pix_valid_q <= 1'b1;
                pix_q       <= {r_q, g_q, wr_byte};
                pix_x_q     <= x_q;
                pix_y_q     <= y_q;
                comp_q      <= CompR;
                if (x_q == XLast) begin
                  x_q <= '0;
                  y_q <= y_q + COORD_W'(1);
                end else begin
                  x_q <= x_q + COORD_W'(1);
                end
              end
            endcase
          end else begin
            err_q <= 1'b1;
          end
        end
        if (cfg_err) err_q <= 1'b1;
        // Two drain cycles cover the compare and accumulate stages.
        if (state_q == StDrain) begin
          if (drain_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        range_q[k] <= '{lo: 24'hFFFFFF, hi: 24'h000000};
      end
    end else if (cfg_ok) begin
      range_q[cfg_class] <= '{lo: cfg_lo, hi: cfg_hi};
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
    bbox_class_acc #(
      .CoordWidth(COORD_W)
    ) u_acc (
      .clk_i  (CLOCK_50),
      .rst_i  (reset),
      .clear_i(start),
      .valid_i(pix_valid_q),
      .x_i    (pix_x_q),
      .y_i    (pix_y_q),
      .pixel_i(pix_q),
      .range_i(range_q[k]),
      .found_o(found_w[k]),
      .box_o  (box_w[k])
    );
  end

  // Unknown classes and classes without a match read as zero.
  always_comb begin
    rd_box = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (32'(rd_class) == k && found_w[k]) rd_box = box_w[k];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      coord_q    <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) coord_q <= done_q ? rd_box : '0;
    end
  end

  assign coordinates = coord_q;
  assign rd_valid    = rd_valid_q;
  assign found       = found_w;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bbox_stream_multi.sv
// Directed bench for bbox_stream_multi: an 8x8 instance and a default 100x100 instance,
// read results checked through a scoreboard queue per instance.
`timescale 1ns/1ps
module tb_bbox_stream_multi;
  import bbox_pkg::*;

  localparam int EndCmd = 99999;

  logic        clk;
  logic        reset     [2];
  logic        wr_en     [2];
  logic [31:0] hvi       [2];
  logic        cfg_wr    [2];
  logic [0:0]  cfg_class [2];
  logic [23:0] cfg_lo    [2];
  logic [23:0] cfg_hi    [2];
  logic        rd_en     [2];
  logic [0:0]  rd_class  [2];
  logic [31:0] coords    [2];
  logic        rd_valid  [2];
  logic [1:0]  found     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];

  int n_checks;
  int n_fail;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bbox_stream_multi #(.WIDTH(8), .HEIGHT(8)) dut0 (
    .CLOCK_50(clk), .reset(reset[0]), .wr_en(wr_en[0]), .hex_value_index(hvi[0]),
    .cfg_wr(cfg_wr[0]), .cfg_class(cfg_class[0]), .cfg_lo(cfg_lo[0]), .cfg_hi(cfg_hi[0]),
    .rd_en(rd_en[0]), .rd_class(rd_class[0]), .coordinates(coords[0]),
    .rd_valid(rd_valid[0]), .found(found[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  bbox_stream_multi dut1 (
    .CLOCK_50(clk), .reset(reset[1]), .wr_en(wr_en[1]), .hex_value_index(hvi[1]),
    .cfg_wr(cfg_wr[1]), .cfg_class(cfg_class[1]), .cfg_lo(cfg_lo[1]), .cfg_hi(cfg_hi[1]),
    .rd_en(rd_en[1]), .rd_class(rd_class[1]), .coordinates(coords[1]),
    .rd_valid(rd_valid[1]), .found(found[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      wr_en[d]  = 1'b0;
      cfg_wr[d] = 1'b0;
      rd_en[d]  = 1'b0;
    end
  endtask

  task automatic set_wr(input int d, input int idx, input logic [7:0] b);
    wr_en[d] = 1'b1;
    hvi[d]   = {b, 24'(idx)};
  endtask

  task automatic set_cfg(input int d, input int cls, input logic [23:0] lo, input logic [23:0] hi);
    cfg_wr[d]    = 1'b1;
    cfg_class[d] = 1'(cls);
    cfg_lo[d]    = lo;
    cfg_hi[d]    = hi;
  endtask

  task automatic set_rd(input int d, input int cls, input logic [31:0] exp);
    rd_en[d]    = 1'b1;
    rd_class[d] = 1'(cls);
    if (d == 0) sb0.push_back(exp);
    else        sb1.push_back(exp);
  endtask

  function automatic logic [31:0] mk_box(input int x0, input int y0, input int x1, input int y1);
    bbox_t bx;
    bx.x_min = 8'(x0);
    bx.y_min = 8'(y0);
    bx.x_max = 8'(x1);
    bx.y_max = 8'(y1);
    return bx;
  endfunction

  // 0: three red pixels on black; 1: 100x100 grey with white (0,0) and black (99,99);
  // other: every pixel red.
  function automatic logic [23:0] color(input int mode, input int x, input int y);
    if (mode == 0) begin
      if ((x == 2 && y == 3) || (x == 5 && y == 6) || (x == 4 && y == 1)) return 24'hFF0000;
      return 24'h000000;
    end else if (mode == 1) begin
      if (x == 0 && y == 0) return 24'hFFFFFF;
      if (x == 99 && y == 99) return 24'h000000;
      return 24'h808080;
    end
    return 24'hE01020;
  endfunction

  task automatic send_bytes(input int d, input int mode, input int w, input int from, input int to);
    int          p;
    logic [23:0] c;
    logic [7:0]  b;
    for (int i = from; i <= to; i++) begin
      p = i / 3;
      c = color(mode, p % w, p / w);
      b = (i % 3 == 0) ? c[23:16] : (i % 3 == 1) ? c[15:8] : c[7:0];
      set_wr(d, i, b);
      tick();
    end
  endtask

  task automatic end_and_drain(input int d);
    set_wr(d, EndCmd, 8'h00);
    tick();
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (rd_valid[0]) begin
      check("rd0_queued", 32'(sb0.size() != 0), 32'd1);
      if (sb0.size() != 0) check("rd0_coord", coords[0], sb0.pop_front());
    end
    if (rd_valid[1]) begin
      check("rd1_queued", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) check("rd1_coord", coords[1], sb1.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; wr_en[d] = 1'b0; hvi[d] = '0; cfg_wr[d] = 1'b0; cfg_class[d] = '0;
      cfg_lo[d] = '0; cfg_hi[d] = '0; rd_en[d] = 1'b0; rd_class[d] = '0;
    end
    tick();
    tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    check("rst_coord", coords[0], 32'd0);
    check("rst_rd_valid", rd_valid[0], 1'b0);
    check("rst_found", found[0], 2'b00);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_err", err[0], 1'b0);

    // Three red pixels, reads issued every cycle across END_CMD.
    set_cfg(0, 0, 24'hC80000, 24'hFF3232);
    tick();
    send_bytes(0, 0, 8, 0, 0);
    check("t1_busy", busy[0], 1'b1);
    send_bytes(0, 0, 8, 1, 191);
    set_wr(0, EndCmd, 8'h00);
    set_rd(0, 0, 32'd0);
    tick();
    check("t1_busy_end", busy[0], 1'b0);
    check("t1_done_t0", done[0], 1'b0);
    set_rd(0, 0, 32'd0);
    tick();
    check("t1_done_t1", done[0], 1'b0);
    set_rd(0, 0, 32'd0);
    tick();
    check("t1_done_t2", done[0], 1'b1);
    set_rd(0, 0, mk_box(2, 1, 5, 6));
    tick();
    set_rd(0, 1, 32'd0);
    tick();
    check("t1_found", found[0], 2'b01);
    check("t1_err", err[0], 1'b0);
    tick();

    // Out-of-order index is dropped and flagged, then the frame resumes.
    send_bytes(0, 0, 8, 0, 4);
    check("ooo_err_before", err[0], 1'b0);
    set_wr(0, 7, 8'hAA);
    tick();
    check("ooo_err", err[0], 1'b1);
    send_bytes(0, 0, 8, 5, 191);
    end_and_drain(0);
    check("ooo_done", done[0], 1'b1);
    check("ooo_found", found[0], 2'b01);
    set_rd(0, 0, mk_box(2, 1, 5, 6));
    tick();
    tick();

    // Short frame: 30 bytes cover pixels 0-9.
    send_bytes(0, 2, 8, 0, 29);
    set_wr(0, EndCmd, 8'h00);
    tick();
    check("part_done_t0", done[0], 1'b0);
    tick();
    check("part_done_t1", done[0], 1'b0);
    tick();
    check("part_done_t2", done[0], 1'b1);
    check("part_err", err[0], 1'b1);
    set_rd(0, 0, mk_box(0, 0, 7, 1));
    tick();
    tick();

    // Range load while busy is rejected.
    send_bytes(0, 0, 8, 0, 9);
    check("cfgb_err_before", err[0], 1'b0);
    set_cfg(0, 0, 24'h000000, 24'hFFFFFF);
    send_bytes(0, 0, 8, 10, 10);
    check("cfgb_err", err[0], 1'b1);
    send_bytes(0, 0, 8, 11, 191);
    end_and_drain(0);
    check("cfgb_found", found[0], 2'b01);
    set_rd(0, 1, 32'd0);
    tick();
    set_rd(0, 0, mk_box(2, 1, 5, 6));
    tick();
    tick();

    // Reset mid-frame restores match-nothing ranges.
    send_bytes(0, 0, 8, 0, 49);
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    check("mrst_coord", coords[0], 32'd0);
    check("mrst_rd_valid", rd_valid[0], 1'b0);
    check("mrst_found", found[0], 2'b00);
    check("mrst_busy", busy[0], 1'b0);
    check("mrst_done", done[0], 1'b0);
    check("mrst_err", err[0], 1'b0);
    send_bytes(0, 0, 8, 0, 191);
    end_and_drain(0);
    check("mrst_done_after", done[0], 1'b1);
    check("mrst_found_after", found[0], 2'b00);
    set_rd(0, 0, 32'd0);
    tick();
    tick();

    // Default 100x100: exact white and exact black single pixels on grey.
    set_cfg(1, 0, 24'hFFFFFF, 24'hFFFFFF);
    tick();
    set_cfg(1, 1, 24'h000000, 24'h000000);
    tick();
    send_bytes(1, 1, 100, 0, 29999);
    end_and_drain(1);
    check("big_done", done[1], 1'b1);
    check("big_found", found[1], 2'b11);
    check("big_err", err[1], 1'b0);
    set_rd(1, 0, mk_box(0, 0, 0, 0));
    tick();
    set_rd(1, 1, mk_box(99, 99, 99, 99));
    tick();
    tick();

    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
